// File: rtl/whack_pkg.sv
// Shared types and LFSR constants for the whack-a-mole round controller.
package whack_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_JUDGE,
    S_DONE
  } state_t;

  typedef enum logic {
    OUT_HIT,
    OUT_MISS
  } outcome_t;

  localparam logic [7:0] LFSR_SEED = 8'h01;
  // Feedback taps at bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/whack_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, one step per cycle, seeded on reset.
// No handshake; the sequence never reaches zero from a non-zero seed.
module whack_lfsr8
  import whack_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] q
);

  logic [7:0] lfsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/whack_round_ctrl.sv
// Round sequencer: loads the timer, lights a mole, judges hits; start->timer_load 1 cycle, event->next load 2 cycles.
// No backpressure: start, hit_valid and timer_timeout are dropped outside the states that accept them.
module whack_round_ctrl
  import whack_pkg::*;
#(
  parameter int NUM_ROUNDS     = 16,
  parameter int START_INTERVAL = 7,
  parameter int MIN_INTERVAL   = 2,
  parameter int START_LIVES    = 3,
  parameter int HITS_PER_LEVEL = 4,
  parameter int SCORE_W        = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               hit_valid,
  input  logic [2:0]         hit_idx,
  input  logic               timer_timeout,
  output logic               timer_load,
  output logic [2:0]         timer_interval,
  output logic               timer_run,
  output logic [2:0]         mole_sel,
  output logic               mole_on,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         lives,
  output logic [2:0]         level,
  output logic               game_over,
  output logic               busy
);

  state_t               state_q, state_d;
  outcome_t             outcome_q, outcome_d;
  logic [2:0]           mole_q, mole_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [1:0]           lives_q, lives_d, lives_post;
  logic [2:0]           level_q, level_d;
  logic [7:0]           round_cnt_q, round_cnt_d;
  logic [7:0]           hit_cnt_q, hit_cnt_d;
  logic [2:0]           interval_q, interval_d;
  logic [7:0]           lfsr;
  logic                 lfsr_unused;

  whack_lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr)
  );

  // Only the low bits pick a mole; the rest just keep the sequence long.
  assign lfsr_unused = ^lfsr[7:3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      outcome_q   <= OUT_HIT;
      mole_q      <= '0;
      score_q     <= '0;
      lives_q     <= '0;
      level_q     <= '0;
      round_cnt_q <= '0;
      hit_cnt_q   <= '0;
      interval_q  <= 3'(START_INTERVAL);
    end else begin
      state_q     <= state_d;
      outcome_q   <= outcome_d;
      mole_q      <= mole_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      level_q     <= level_d;
      round_cnt_q <= round_cnt_d;
      hit_cnt_q   <= hit_cnt_d;
      interval_q  <= interval_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    outcome_d   = outcome_q;
    mole_d      = mole_q;
    score_d     = score_q;
    lives_d     = lives_q;
    level_d     = level_q;
    round_cnt_d = round_cnt_q;
    hit_cnt_d   = hit_cnt_q;
    interval_d  = interval_q;
    lives_post  = lives_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_LOAD;
          score_d     = '0;
          lives_d     = 2'(START_LIVES);
          level_d     = '0;
          round_cnt_d = '0;
          hit_cnt_d   = '0;
          interval_d  = 3'(START_INTERVAL);
        end
      end
      S_LOAD: begin
        mole_d  = lfsr[2:0];
        state_d = S_RUN;
      end
      S_RUN: begin
        // A press wins over a coincident timeout.
        if (hit_valid) begin
          outcome_d = (hit_idx == mole_q) ? OUT_HIT : OUT_MISS;
          state_d   = S_JUDGE;
        end else if (timer_timeout) begin
          outcome_d = OUT_MISS;
          state_d   = S_JUDGE;
        end
      end
      S_JUDGE: begin
        round_cnt_d = round_cnt_q + 8'd1;
        if (outcome_q == OUT_HIT) begin
          if (score_q != '1) score_d = score_q + SCORE_W'(1);
          if (hit_cnt_q + 8'd1 == 8'(HITS_PER_LEVEL)) begin
            hit_cnt_d  = '0;
            if (level_q != 3'd7) level_d = level_q + 3'd1;
            interval_d = (interval_q > 3'(MIN_INTERVAL)) ? interval_q - 3'd1
                                                         : 3'(MIN_INTERVAL);
          end else begin
            hit_cnt_d = hit_cnt_q + 8'd1;
          end
        end else if (lives_q != 2'd0) begin
          lives_post = lives_q - 2'd1;
        end
        lives_d = lives_post;
        if (lives_post == 2'd0 || round_cnt_d == 8'(NUM_ROUNDS)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign timer_load     = (state_q == S_LOAD);
  assign timer_run      = (state_q == S_RUN);
  assign mole_on        = (state_q == S_RUN);
  assign busy           = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_JUDGE);
  assign game_over      = (state_q == S_DONE);
  assign timer_interval = interval_q;
  assign mole_sel       = mole_q;
  assign score          = score_q;
  assign lives          = lives_q;
  assign level          = level_q;

endmodule

// File: tb/tb_whack_round_ctrl.sv
// Bench for whack_round_ctrl: game-level model (hit/miss counts) checked every cycle,
// plus directed literal checks; a second instance with more rounds exercises the interval floor.
module tb_whack_round_ctrl;

  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_JUDGE = 3, P_DONE = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic hit_valid = 1'b0;
  logic [2:0] hit_idx = 3'd0;
  logic timer_timeout = 1'b0;

  logic tl, tr, mo, go, bz;
  logic [2:0] ti, ms, lvl;
  logic [7:0] sc;
  logic [1:0] lv;

  logic u2_tl, u2_tr, u2_mo, u2_go, u2_bz;
  logic [2:0] u2_ti, u2_ms, u2_lvl;
  logic [7:0] u2_sc;
  logic [1:0] u2_lv;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  whack_round_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .hit_valid(hit_valid), .hit_idx(hit_idx),
    .timer_timeout(timer_timeout), .timer_load(tl), .timer_interval(ti), .timer_run(tr),
    .mole_sel(ms), .mole_on(mo), .score(sc), .lives(lv), .level(lvl), .game_over(go), .busy(bz)
  );

  whack_round_ctrl #(.NUM_ROUNDS(64)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .hit_valid(hit_valid), .hit_idx(hit_idx),
    .timer_timeout(timer_timeout), .timer_load(u2_tl), .timer_interval(u2_ti), .timer_run(u2_tr),
    .mole_sel(u2_ms), .mole_on(u2_mo), .score(u2_sc), .lives(u2_lv), .level(u2_lvl),
    .game_over(u2_go), .busy(u2_bz)
  );

  // ---------------- game model ----------------
  int         m_ph = P_IDLE;
  int         m_hits = 0;
  int         m_miss = 0;
  int         m_rounds = 0;
  logic       m_started = 1'b0;
  logic       m_pend = 1'b0;
  logic [2:0] m_mole = 3'd0;
  logic [7:0] m_lf = 8'h01;

  function automatic logic [7:0] lf_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic int lives_of(input int misses);
    return (misses >= 3) ? 0 : 3 - misses;
  endfunction

  always @(posedge clk or negedge rst_n) begin : mdl
    int nh, nm, nr;
    if (!rst_n) begin
      m_ph <= P_IDLE; m_hits <= 0; m_miss <= 0; m_rounds <= 0;
      m_started <= 1'b0; m_pend <= 1'b0; m_mole <= 3'd0; m_lf <= 8'h01;
    end else begin
      m_lf <= lf_step(m_lf);
      case (m_ph)
        P_IDLE, P_DONE: if (start) begin
          m_ph <= P_LOAD; m_hits <= 0; m_miss <= 0; m_rounds <= 0; m_started <= 1'b1;
        end
        P_LOAD: begin m_mole <= m_lf[2:0]; m_ph <= P_RUN; end
        P_RUN: begin
          if (hit_valid) begin m_pend <= (hit_idx == m_mole); m_ph <= P_JUDGE; end
          else if (timer_timeout) begin m_pend <= 1'b0; m_ph <= P_JUDGE; end
        end
        default: begin
          nh = m_hits + (m_pend ? 1 : 0);
          nm = m_miss + (m_pend ? 0 : 1);
          nr = m_rounds + 1;
          m_hits <= nh; m_miss <= nm; m_rounds <= nr;
          m_ph <= (lives_of(nm) == 0 || nr == 16) ? P_DONE : P_LOAD;
        end
      endcase
    end
  end

  function automatic int exp_score();  return (m_hits > 255) ? 255 : m_hits; endfunction
  function automatic int exp_level();  return (m_hits / 4 > 7) ? 7 : m_hits / 4; endfunction
  function automatic int exp_int();    return (7 - m_hits / 4 < 2) ? 2 : 7 - m_hits / 4; endfunction
  function automatic int exp_lives();  return m_started ? lives_of(m_miss) : 0; endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cyc_timer_load", int'(tl), int'(m_ph == P_LOAD));
    chk("cyc_timer_run", int'(tr), int'(m_ph == P_RUN));
    chk("cyc_mole_on", int'(mo), int'(m_ph == P_RUN));
    chk("cyc_busy", int'(bz), int'(m_ph == P_LOAD || m_ph == P_RUN || m_ph == P_JUDGE));
    chk("cyc_game_over", int'(go), int'(m_ph == P_DONE));
    chk("cyc_mole_sel", int'(ms), int'(m_mole));
    chk("cyc_score", int'(sc), exp_score());
    chk("cyc_lives", int'(lv), exp_lives());
    chk("cyc_level", int'(lvl), exp_level());
    chk("cyc_interval", int'(ti), exp_int());
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_ph(input int p, input string nm);
    int n = 0;
    while (m_ph != p && n < 40) begin tick(); n++; end
    if (m_ph != p) chk(nm, m_ph, p);
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  // One RUN event, then through JUDGE: returns in LOAD or DONE.
  task automatic ev(input bit v, input bit correct, input bit to);
    wait_ph(P_RUN, "wait_run");
    hit_valid = v; hit_idx = correct ? m_mole : (m_mole ^ 3'd1); timer_timeout = to;
    tick();
    hit_valid = 1'b0; hit_idx = 3'd0; timer_timeout = 1'b0;
    tick();
  endtask

  task automatic hit2();
    int n = 0;
    while (!u2_tr && n < 40) begin tick(); n++; end
    if (!u2_tr) chk("u2_wait_run", int'(u2_tr), 1);
    hit_valid = 1'b1; hit_idx = u2_ms;
    tick();
    hit_valid = 1'b0; hit_idx = 3'd0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst_score", int'(sc), 0);
    chk("rst_lives", int'(lv), 0);
    chk("rst_interval", int'(ti), 7);
    chk("rst_busy", int'(bz), 0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();

    // Game 1: level-up, start ignored while busy, misses, coincident events.
    pulse_start();
    chk("start_timer_load", int'(tl), 1);
    chk("start_lives", int'(lv), 3);
    chk("start_score", int'(sc), 0);
    chk("start_interval", int'(ti), 7);
    chk("start_busy", int'(bz), 1);
    ev(1, 1, 0);
    chk("hit1_score", int'(sc), 1);
    chk("hit1_reload", int'(tl), 1);
    chk("hit1_lives", int'(lv), 3);
    for (int i = 0; i < 3; i++) ev(1, 1, 0);
    chk("lvl1_level", int'(lvl), 1);
    chk("lvl1_interval", int'(ti), 6);
    wait_ph(P_RUN, "busy_start_run");
    start = 1'b1; tick(); start = 1'b0;
    chk("busy_start_run_hold", int'(tr), 1);
    chk("busy_start_score", int'(sc), 4);
    ev(1, 0, 0);
    chk("wrong_lives", int'(lv), 2);
    ev(1, 1, 1);
    chk("both_ok_score", int'(sc), 5);
    chk("both_ok_lives", int'(lv), 2);
    ev(1, 0, 1);
    chk("both_bad_lives", int'(lv), 1);
    ev(0, 0, 1);
    chk("over_lives", int'(lv), 0);
    chk("over_game_over", int'(go), 1);
    chk("over_timer_run", int'(tr), 0);
    hit_valid = 1'b1; hit_idx = m_mole; timer_timeout = 1'b1;
    tick();
    hit_valid = 1'b0; timer_timeout = 1'b0;
    tick(); tick();
    chk("done_hit_score", int'(sc), 5);
    chk("done_hit_level", int'(lvl), 1);
    chk("done_hit_over", int'(go), 1);

    // Game 2: restart from DONE, then reset mid-RUN.
    pulse_start();
    chk("restart_lives", int'(lv), 3);
    chk("restart_score", int'(sc), 0);
    chk("restart_level", int'(lvl), 0);
    chk("restart_interval", int'(ti), 7);
    wait_ph(P_RUN, "g2_run");
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_run", int'(tr), 0);
    chk("arst_mole_on", int'(mo), 0);
    chk("arst_busy", int'(bz), 0);
    chk("arst_lives", int'(lv), 0);
    chk("arst_mole_sel", int'(ms), 0);
    chk("arst_interval", int'(ti), 7);
    chk("arst_game_over", int'(go), 0);
    chk("arst_u2_all", int'({u2_tl, u2_tr, u2_mo, u2_go, u2_bz, u2_ms, u2_lvl, u2_sc, u2_lv}), 0);
    chk("arst_u2_interval", int'(u2_ti), 7);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Game 3: a full 16-round all-correct game; the long instance keeps going.
    pulse_start();
    for (int i = 0; i < 16; i++) ev(1, 1, 0);
    chk("full_game_over", int'(go), 1);
    chk("full_score", int'(sc), 16);
    chk("full_level", int'(lvl), 4);
    chk("full_interval", int'(ti), 3);
    chk("u2_full_score", int'(u2_sc), 16);
    chk("u2_full_busy", int'(u2_bz), 1);
    for (int k = 1; k <= 16; k++) begin
      hit2();
      if (k % 4 == 0) chk("u2_floor_interval", int'(u2_ti), 2);
      if (k == 4) chk("u2_level5", int'(u2_lvl), 5);
    end
    chk("u2_level_sat", int'(u2_lvl), 7);
    chk("u2_score32", int'(u2_sc), 32);
    chk("u2_lives", int'(u2_lv), 3);
    chk("u2_mole_on", int'(u2_mo), 0);
    chk("u2_load_or_run", int'(u2_tl | u2_tr | u2_go), 1);
    chk("g3_dut1_score_held", int'(sc), 16);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
